mem_bus_arbiter: RTL



---
 rtl/bus_arb_pkg.sv | 16 +
 rtl/bus_watchdog.sv | 32 +++
 rtl/mem_bus_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package bus_arb_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

  // One-hot bus owner; GNT_NONE while no transaction is in flight.
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  localparam logic [31:0] TIMEOUT_RDATA_DEFAULT = 32'hBAD0_BAD0;

endpackage

// File: rtl/bus_watchdog.sv
// Busy-cycle counter that pulses o_expire on the last allowed unacknowledged cycle.
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] r_cnt;
  logic            w_at_last;

  assign w_at_last = (r_cnt == LastCnt);
  // TIMEOUT of 0 disables expiry entirely.
  assign o_expire  = (TIMEOUT != 0) && i_en && w_at_last;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_at_last) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the native valid/ready memory bus between CPU (m0) and DMA (m1),
// one transaction in flight, with a watchdog that terminates unacknowledged transactions.
module mem_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W        = 32,
  parameter int unsigned       DATA_W        = 32,
  parameter int unsigned       TIMEOUT       = 256,
  parameter logic [DATA_W-1:0] TIMEOUT_RDATA = DATA_W'(TIMEOUT_RDATA_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  m0_valid,
  output logic                  m0_ready,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [DATA_W/8-1:0]   m0_wstrb,
  output logic [DATA_W-1:0]     m0_rdata,
  input  logic                  m1_valid,
  output logic                  m1_ready,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  s_valid,
  input  logic                  s_ready,
  output logic [ADDR_W-1:0]     s_addr,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wstrb,
  input  logic [DATA_W-1:0]     s_rdata,
  output logic [1:0]            grant,
  output logic                  timeout_err,
  input  logic                  err_clr
);

  arb_state_e        r_state;
  arb_state_e        w_state_next;
  logic [1:0]        r_grant;
  logic              r_last_owner;  // 1: m1 was served last
  logic              r_timeout_err;
  logic [1:0]        w_pick;
  logic              w_busy;
  logic              w_expire;
  logic              w_done;
  logic [DATA_W-1:0] w_resp_data;

  assign w_busy      = (r_state == StBusy);
  assign w_done      = w_busy && (s_ready || w_expire);
  // A slave ack in the expiry cycle wins over the timeout.
  assign w_resp_data = s_ready ? s_rdata : TIMEOUT_RDATA;

  bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .resetn  (resetn),
    .i_clr   (!w_busy),
    .i_en    (w_busy && !s_ready),
    .o_expire(w_expire)
  );

  always_comb begin
    w_pick = GNT_NONE;
    if (m0_valid && m1_valid) begin
      w_pick = r_last_owner ? GNT_M0 : GNT_M1;
    end else if (m0_valid) begin
      w_pick = GNT_M0;
    end else if (m1_valid) begin
      w_pick = GNT_M1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (m0_valid || m1_valid) w_state_next = StBusy;
      StBusy:  if (w_done) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_grant      <= GNT_NONE;
      r_last_owner <= 1'b1;
    end else if (!w_busy) begin
      r_grant <= w_pick;
    end else if (w_done) begin
      r_grant      <= GNT_NONE;
      r_last_owner <= (r_grant == GNT_M1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_timeout_err <= 1'b0;
    end else if (w_busy && w_expire) begin
      r_timeout_err <= 1'b1;
    end else if (err_clr) begin
      r_timeout_err <= 1'b0;
    end
  end

  always_comb begin
    s_valid  = w_busy;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    if (w_busy) begin
      unique case (r_grant)
        GNT_M0: begin
          s_addr   = m0_addr;
          s_wdata  = m0_wdata;
          s_wstrb  = m0_wstrb;
          m0_ready = w_done;
          m0_rdata = w_done ? w_resp_data : '0;
        end
        GNT_M1: begin
          s_addr   = m1_addr;
          s_wdata  = m1_wdata;
          s_wstrb  = m1_wstrb;
          m1_ready = w_done;
          m1_rdata = w_done ? w_resp_data : '0;
        end
        default: ;
      endcase
    end
  end

  assign grant       = r_grant;
  assign timeout_err = r_timeout_err;

endmodule
